// File: rtl/tone_decoder_if.sv
// Signal bundle between a square-wave source and the tone decoder.
// The source drives tone_in (master); the decoder drives the results (slave).
interface tone_decoder_if #(
    parameter int CNT_W = 17
);
    logic             tone_in;
    logic             period_strobe;
    logic [CNT_W-1:0] period;
    logic             note_valid;
    logic [2:0]       note_idx;
    logic [7:0]       note_onehot;

    modport master (
        output tone_in,
        input  period_strobe, period, note_valid, note_idx, note_onehot
    );

    modport slave (
        input  tone_in,
        output period_strobe, period, note_valid, note_idx, note_onehot
    );
endinterface

// File: rtl/tone_decoder.sv
// Square-wave tone decoder: measures the period between rising edges of a
// 1-bit audio input, classifies it against the eight C-major scale notes and
// reports a note once LOCK_COUNT consecutive periods agree.
module tone_decoder #(
    parameter int PITCH_0    = 15289,
    parameter int PITCH_1    = 13621,
    parameter int PITCH_2    = 12135,
    parameter int PITCH_3    = 11454,
    parameter int PITCH_4    = 10204,
    parameter int PITCH_5    = 9091,
    parameter int PITCH_6    = 8099,
    parameter int PITCH_7    = 7645,
    parameter int TOL        = 64,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 65535,
    parameter int CNT_W      = 17
) (
    input  logic           clk,
    input  logic           reset,
    tone_decoder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

    localparam logic [CNT_W:0] TOL_X = (CNT_W+1)'(TOL);

    // Expected full period of note n, widened by one bit so the tolerance
    // window arithmetic cannot wrap.
    function automatic logic [CNT_W:0] exp_period(input int n);
        case (n)
            0:       return (CNT_W+1)'(2 * PITCH_0);
            1:       return (CNT_W+1)'(2 * PITCH_1);
            2:       return (CNT_W+1)'(2 * PITCH_2);
            3:       return (CNT_W+1)'(2 * PITCH_3);
            4:       return (CNT_W+1)'(2 * PITCH_4);
            5:       return (CNT_W+1)'(2 * PITCH_5);
            6:       return (CNT_W+1)'(2 * PITCH_6);
            default: return (CNT_W+1)'(2 * PITCH_7);
        endcase
    endfunction

    state_t           state_q;
    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic             strobe_q;
    logic [3:0]       match_cnt_q;
    logic [2:0]       candidate_q;
    logic             valid_q;
    logic [2:0]       idx_q;
    logic [7:0]       onehot_q;

    logic             edge_det;
    logic             at_timeout;
    logic             hit;
    logic [2:0]       hit_idx;
    logic [3:0]       match_inc;

    assign edge_det   = sync2_q & ~prev_q;
    assign at_timeout = (cnt_q == CNT_W'(TIMEOUT));

    // Classify the running count against every note window; lowest index wins.
    always_comb begin
        logic [CNT_W:0] cnt_x;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        hit     = 1'b0;
        hit_idx = 3'd0;
        cnt_x   = {1'b0, cnt_q};
        for (int n = 7; n >= 0; n--) begin
            if ((cnt_x + TOL_X >= exp_period(n)) && (cnt_x <= exp_period(n) + TOL_X)) begin
                hit     = 1'b1;
                hit_idx = 3'(n);
            end
        end
    end

    // Next match count for a hit: extend the streak of the same candidate
    // (saturating at 15) or start a new streak at 1.
    always_comb begin
        match_inc = 4'd1;
        if (hit_idx == candidate_q)
            match_inc = (match_cnt_q == 4'd15) ? 4'd15 : match_cnt_q + 4'd1;
    end

    // Input synchronizer, period counter and note-lock FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            period_q    <= '0;
            strobe_q    <= 1'b0;
            match_cnt_q <= 4'd0;
            candidate_q <= 3'd0;
            valid_q     <= 1'b0;
            idx_q       <= 3'd0;
            onehot_q    <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of the others, e.g. sync2_q takes the old sync1_q.
            sync1_q  <= bus.tone_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            cnt_q    <= edge_det ? CNT_W'(1) : (at_timeout ? cnt_q : cnt_q + 1'b1);
            strobe_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (edge_det)
                        state_q <= ARMED;
                end
                ARMED, LOCKED: begin
                    if (edge_det) begin
                        period_q <= cnt_q;
                        strobe_q <= 1'b1;
                        if (!hit) begin
                            match_cnt_q <= 4'd0;
                            valid_q     <= 1'b0;
                            onehot_q    <= 8'd0;
                            state_q     <= ARMED;
                        end else if (!(state_q == LOCKED && hit_idx == idx_q)) begin
                            candidate_q <= hit_idx;
                            match_cnt_q <= match_inc;
                            if (match_inc >= 4'(LOCK_COUNT)) begin
                                state_q  <= LOCKED;
                                valid_q  <= 1'b1;
                                idx_q    <= hit_idx;
                                onehot_q <= 8'd1 << hit_idx;
                            end
                        end
                    end else if (at_timeout) begin
                        match_cnt_q <= 4'd0;
                        valid_q     <= 1'b0;
                        onehot_q    <= 8'd0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.period_strobe = strobe_q;
    assign bus.period        = period_q;
    assign bus.note_valid    = valid_q;
    assign bus.note_idx      = idx_q;
    assign bus.note_onehot   = onehot_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder, with pitches scaled down so every scenario
// runs in a few thousand cycles. Note periods: 300 268 240 226 200 180 160 150,
// tolerance 4, lock after 4 agreeing periods, silence after 1000 cycles.
module tb_tone_decoder;

    localparam int CNT_W   = 12;
    localparam int TIMEOUT = 1000;

    typedef struct {
        int period;
        int valid;
        int idx;
        int onehot;
        int cyc;
    } rec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    tone_decoder_if #(.CNT_W(CNT_W)) bus ();

    tone_decoder #(
        .PITCH_0(150), .PITCH_1(134), .PITCH_2(120), .PITCH_3(113),
        .PITCH_4(100), .PITCH_5(90),  .PITCH_6(80),  .PITCH_7(75),
        .TOL(4), .LOCK_COUNT(4), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t recs[$];
    int   cyc        = 0;
    int   fall_cyc   = -1;
    logic valid_prev = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Record every strobe and the cycle note_valid falls, sampled 1 ns after the edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.period_strobe === 1'b1)
            recs.push_back('{int'(bus.period), int'(bus.note_valid), int'(bus.note_idx),
                             int'(bus.note_onehot), cyc});
        if (valid_prev === 1'b1 && bus.note_valid === 1'b0)
            fall_cyc = cyc;
        valid_prev = bus.note_valid;
    end

    function automatic rec_t get(input int i);
        rec_t r;
        r = '{-1, -1, -1, -1, -1};
        if (i < recs.size())
            r = recs[i];
        return r;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_strobe"}, bus.period_strobe, 0);
        check({tag, "_period"}, bus.period, 0);
        check({tag, "_valid"},  bus.note_valid, 0);
        check({tag, "_idx"},    bus.note_idx, 0);
        check({tag, "_onehot"}, bus.note_onehot, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset       = 1'b1;
        bus.tone_in = 1'b0;
        repeat (2) @(negedge clk);
        check_zero(tag);
        reset = 1'b0;
        recs.delete();
        fall_cyc = -1;
    endtask

    // n square-wave periods of p cycles, each starting with a rising edge.
    task automatic send(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            bus.tone_in = 1'b1;
            repeat (p / 2) @(negedge clk);
            bus.tone_in = 1'b0;
            repeat (p - p / 2) @(negedge clk);
        end
    endtask

    task automatic check_rec(input string tag, input int i, input int period,
                             input int valid, input int idx, input int onehot);
        rec_t r;
        r = get(i);
        check({tag, "_period"}, r.period, period);
        check({tag, "_valid"},  r.valid,  valid);
        check({tag, "_idx"},    r.idx,    idx);
        check({tag, "_onehot"}, r.onehot, onehot);
    endtask

    initial begin
        bus.tone_in = 1'b0;

        // Note 0: six edges give five captures, lock on the fourth.
        do_reset("rst0");
        send(300, 6);
        check("t1_count", recs.size(), 5);
        check_rec("t1_s1", 0, 300, 0, 0, 0);
        check_rec("t1_s3", 2, 300, 0, 0, 0);
        check_rec("t1_s4", 3, 300, 1, 0, 8'h01);
        check_rec("t1_s5", 4, 300, 1, 0, 8'h01);

        // Locked on note 4, then switch to 151 (note 7): old note held for three strobes.
        do_reset("rst1");
        send(200, 5);
        send(151, 5);
        check("t2_count", recs.size(), 9);
        check_rec("t2_lock4", 3, 200, 1, 4, 8'h10);
        check_rec("t2_s6", 5, 151, 1, 4, 8'h10);
        check_rec("t2_s8", 7, 151, 1, 4, 8'h10);
        check_rec("t2_s9", 8, 151, 1, 7, 8'h80);

        // Tolerance edges around note 5 (180): +4 and -4 lock, +5 never does.
        do_reset("rst2");
        send(184, 5);
        check_rec("t3_hi_lock", 3, 184, 1, 5, 8'h20);
        do_reset("rst3");
        send(176, 5);
        check_rec("t3_lo_lock", 3, 176, 1, 5, 8'h20);
        do_reset("rst4");
        send(185, 6);
        check("t3_out_count", recs.size(), 5);
        check_rec("t3_out_s5", 4, 185, 0, 0, 0);
        check("t3_out_valid", bus.note_valid, 0);

        // Locked on note 2, then silence: valid drops TIMEOUT cycles after the last strobe.
        do_reset("rst5");
        send(240, 5);
        check_rec("t4_lock2", 3, 240, 1, 2, 8'h04);
        begin
            int budget;
            budget = 0;
            while (bus.note_valid === 1'b1 && budget < 1500) begin
                @(negedge clk);
                budget++;
            end
            check("t4_timeout_seen", bus.note_valid, 0);
        end
        check("t4_delay_ok", ((fall_cyc - get(3).cyc) >= TIMEOUT - 1) &&
                             ((fall_cyc - get(3).cyc) <= TIMEOUT + 1), 1);
        check("t4_count", recs.size(), 4);
        check("t4_period_hold", bus.period, 240);
        check("t4_onehot", bus.note_onehot, 0);

        // Locked on note 6, one short period breaks the lock, four good periods relock.
        do_reset("rst6");
        send(160, 5);
        send(40, 1);
        send(160, 5);
        check("t5_count", recs.size(), 10);
        check_rec("t5_lock", 3, 160, 1, 6, 8'h40);
        check_rec("t5_drop", 5, 40, 0, 6, 0);
        check_rec("t5_s9", 8, 160, 0, 6, 0);
        check_rec("t5_relock", 9, 160, 1, 6, 8'h40);

        // Period equal to TIMEOUT: the edge wins and the value is captured.
        do_reset("rst7");
        send(TIMEOUT, 3);
        check("t6_count", recs.size(), 2);
        check_rec("t6_s2", 1, TIMEOUT, 0, 0, 0);

        // One-cycle reset while locked with tone high: outputs clear, first edge only arms.
        do_reset("rst8");
        send(200, 5);
        check("t7_locked", bus.note_valid, 1);
        bus.tone_in = 1'b1;
        reset       = 1'b1;
        @(negedge clk);
        check_zero("t7_rst");
        reset = 1'b0;
        recs.delete();
        repeat (100) @(negedge clk);
        bus.tone_in = 1'b0;
        repeat (100) @(negedge clk);
        send(200, 4);
        check("t7_count", recs.size(), 4);
        check_rec("t7_s1", 0, 200, 0, 0, 0);
        check_rec("t7_s3", 2, 200, 0, 0, 0);
        check_rec("t7_s4", 3, 200, 1, 4, 8'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
